// File: rtl/round_robin_sel6.sv
// Six-channel round-robin select generator: picks one requester, holds the grant
// until done, request drop or HOLD_MAX cycles, then forces one idle cycle.
module round_robin_sel6 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic [5:0] grant,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic       sel_valid_q, sel_valid_d;
  logic [5:0] grant_q, grant_d;
  logic       timeout_q, timeout_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [3:0] pick_s;
  logic       exit_user_s;
  logic       exit_hold_s;
  logic [2:0] ptr_next_s;

  // Rotating priority scan from p; result is {found, index}.
  function automatic logic [3:0] rr_pick(input logic [5:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    idx = p;
    for (int k = 0; k < 6; k++) begin
      if (!res[3] && r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
      idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(req, ptr_q);
  assign exit_user_s = done | ~req[sel_q];
  assign exit_hold_s = (hold_cnt_q == HOLD_LAST);
  assign ptr_next_s  = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;

  // Next-state and next-output computation for the two-state arbiter.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    grant_d     = grant_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_s[3]) begin
          state_d     = GRANT;
          sel_d       = pick_s[2:0];
          sel_valid_d = 1'b1;
          grant_d     = 6'b000001 << pick_s[2:0];
          hold_cnt_d  = 8'd0;
        end else begin
          sel_valid_d = 1'b0;
          grant_d     = 6'b000000;
        end
      end
      GRANT: begin
        // done / request drop win over the hold limit, so timeout only on a pure hold exit
        if (exit_user_s || exit_hold_s) begin
          state_d     = IDLE;
          sel_valid_d = 1'b0;
          grant_d     = 6'b000000;
          ptr_d       = ptr_next_s;
          timeout_d   = ~exit_user_s;
        end else begin
          hold_cnt_d  = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        sel_valid_d = 1'b0;
        grant_d     = 6'b000000;
        ptr_d       = 3'd0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      grant_q     <= 6'b000000;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign grant     = grant_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_round_robin_sel6.sv
// Directed plus random bench for round_robin_sel6: an independent cycle model
// queues expected outputs per edge, and the post-edge samples are compared to it.
module tb_round_robin_sel6;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] req;
  logic       done;
  logic [2:0] sel;
  logic       sel_valid;
  logic [5:0] grant;
  logic       timeout;

  round_robin_sel6 #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .sel_valid(sel_valid), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       v;
    logic [5:0] g;
    logic       t;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  int   m_ptr = 0, m_sel = 0, m_cnt = 0;
  logic m_valid = 1'b0, m_tmo = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    logic ex_user, ex_hold;
    if (!rst_n) begin
      m_ptr = 0; m_sel = 0; m_cnt = 0; m_valid = 1'b0; m_tmo = 1'b0;
    end else if (!m_valid) begin
      m_tmo = 1'b0;
      for (int k = 0; k < 6; k++) begin
        int c;
        c = (m_ptr + k) % 6;
        if (!m_valid && req[c]) begin
          m_sel = c; m_valid = 1'b1; m_cnt = 0;
        end
      end
    end else begin
      ex_user = done || !req[m_sel];
      ex_hold = (m_cnt == HOLD - 1);
      if (ex_user || ex_hold) begin
        m_valid = 1'b0;
        m_tmo   = !ex_user;
        m_ptr   = (m_sel + 1) % 6;
      end else begin
        m_cnt++;
        m_tmo = 1'b0;
      end
    end
    e.sel = 3'(m_sel);
    e.v   = m_valid;
    e.g   = m_valid ? (6'b000001 << m_sel) : 6'b000000;
    e.t   = m_tmo;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_err++;
      $error("FAIL sb_empty: observed %0d expected %0d", 0, 1);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_sel", 32'(sel), 32'(e.sel));
      chk("sb_valid", 32'(sel_valid), 32'(e.v));
      chk("sb_grant", 32'(grant), 32'(e.g));
      chk("sb_timeout", 32'(timeout), 32'(e.t));
    end else begin
      chk("sb_skip", 32'(sel_valid), 32'(sel_valid ^ 1'b1));
    end
  endtask

  // drive one cycle of inputs, predict, clock, then compare after the edge
  task automatic cyc(input logic [5:0] r, input logic d);
    req  = r;
    done = d;
    model_step();
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    int vcnt, tcnt, run, max_run, max_wait;
    int wait_cnt [6];
    logic prev_v;
    logic [5:0] rr;
    logic dd;

    rst_n = 1'b0; req = 6'b0; done = 1'b0;
    @(posedge clk); #1;
    cyc(6'b000000, 1'b0);
    cyc(6'b111111, 1'b1);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(sel_valid), 32'd0);
    rst_n = 1'b1;

    // rotation with wrap: 2, 5, 2
    cyc(6'b100100, 1'b0);
    chk("rot_first_sel", 32'(sel), 32'd2);
    chk("rot_first_grant", 32'(grant), 32'b000100);
    cyc(6'b100100, 1'b0);
    cyc(6'b100100, 1'b1);
    chk("rot_idle", 32'(sel_valid), 32'd0);
    chk("rot_sel_held", 32'(sel), 32'd2);
    cyc(6'b100100, 1'b0);
    chk("rot_second_sel", 32'(sel), 32'd5);
    cyc(6'b100100, 1'b1);
    cyc(6'b100100, 1'b0);
    chk("rot_wrap_sel", 32'(sel), 32'd2);
    cyc(6'b100100, 1'b1);
    cyc(6'b000000, 1'b1);
    chk("done_in_idle", 32'(sel_valid), 32'd0);

    // hold limit: valid for exactly HOLD cycles, one timeout, one idle, regrant
    cyc(6'b000001, 1'b0);
    vcnt = 0; tcnt = 0;
    while (sel_valid && vcnt < 20) begin
      vcnt++;
      cyc(6'b000001, 1'b0);
      if (timeout) tcnt++;
    end
    chk("hold_len", 32'(vcnt), 32'(HOLD));
    chk("hold_timeout_cnt", 32'(tcnt), 32'd1);
    chk("hold_timeout_now", 32'(timeout), 32'd1);
    cyc(6'b000001, 1'b0);
    chk("hold_regrant_valid", 32'(sel_valid), 32'd1);
    chk("hold_regrant_sel", 32'(sel), 32'd0);
    chk("hold_timeout_one_cycle", 32'(timeout), 32'd0);
    cyc(6'b000001, 1'b1);
    cyc(6'b000000, 1'b0);

    // req drop on channel 3, pointer moves to 4
    cyc(6'b001000, 1'b0);
    chk("drop_sel", 32'(sel), 32'd3);
    cyc(6'b001000, 1'b0);
    cyc(6'b000000, 1'b0);
    chk("drop_valid", 32'(sel_valid), 32'd0);
    chk("drop_no_timeout", 32'(timeout), 32'd0);
    cyc(6'b111111, 1'b0);
    chk("drop_ptr4", 32'(sel), 32'd4);
    cyc(6'b111111, 1'b1);

    // done coincides with the last hold cycle
    cyc(6'b100000, 1'b0);
    chk("coinc_sel", 32'(sel), 32'd5);
    for (int k = 0; k < HOLD - 1; k++) cyc(6'b100000, 1'b0);
    chk("coinc_still_valid", 32'(sel_valid), 32'd1);
    cyc(6'b100000, 1'b1);
    chk("coinc_exit", 32'(sel_valid), 32'd0);
    chk("coinc_no_timeout", 32'(timeout), 32'd0);

    // reset mid-grant on channel 4
    cyc(6'b010000, 1'b0);
    chk("rstmid_sel", 32'(sel), 32'd4);
    cyc(6'b010000, 1'b0);
    rst_n = 1'b0;
    cyc(6'b010000, 1'b0);
    chk("rstmid_valid", 32'(sel_valid), 32'd0);
    chk("rstmid_sel0", 32'(sel), 32'd0);
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    cyc(6'b111111, 1'b0);
    chk("rstmid_regrant", 32'(sel), 32'd0);
    cyc(6'b111111, 1'b1);

    // random traffic with invariant and fairness tracking
    rr = 6'b0; run = 0; max_run = 0; max_wait = 0; prev_v = sel_valid;
    for (int i = 0; i < 6; i++) wait_cnt[i] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 6; b++) if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
      dd = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 6; i++) if (!rr[i]) wait_cnt[i] = 0;
      cyc(rr, dd);
      chk("inv_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("inv_sel_range", 32'(sel < 3'd6), 32'd1);
      if (sel_valid) chk("inv_grant_sel", 32'(grant), 32'(6'b000001 << sel));
      run = sel_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (sel_valid && !prev_v) begin
        for (int i = 0; i < 6; i++) begin
          if (i == int'(sel)) wait_cnt[i] = 0;
          else if (rr[i]) wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
      prev_v = sel_valid;
    end
    chk("rand_max_grant_len", 32'(max_run <= HOLD), 32'd1);
    chk("rand_starvation", 32'(max_wait <= 5), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/round_robin_sel6.md
ROUND_ROBIN_SEL6 -- requirements
Module: round_robin_sel6

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, meaning the maximum cycles one grant is held (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 SHALL have port req, input, 6, per-channel requests; bit i requests channel i.
REQ-005 SHALL have port done, input, 1, a consumer pulse ending the current grant.
REQ-006 SHALL have port sel, output, 3, the registered channel index that drives the downstream 6:1 mux select.
REQ-007 SHALL have port sel_valid, output, 1, high while sel holds a live grant.
REQ-008 SHALL have port grant, output, 6, registered one-hot of the granted channel; all-zero when sel_valid is low.
REQ-009 SHALL have port timeout, output, 1, a one-cycle pulse when a grant is ended by HOLD_MAX.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 SHALL keep a 3-bit round-robin pointer ptr in 0..5; values 6 and 7 are never reachable.
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE: sel unchanged, sel_valid=0, grant=0.
REQ-013 In IDLE with req!=0, the block SHALL select the first set bit scanning ptr, ptr+1, ... with wrap 5->0, then enter GRANT on the next edge.
REQ-014 On GRANT entry, the block SHALL load sel with the winner, set sel_valid=1, set grant=1<<winner, and clear hold_cnt to 0.
REQ-015 Arbitration latency SHALL be exactly 1 cycle: req sampled in IDLE at edge N gives sel_valid=1 after edge N.
REQ-016 In GRANT, hold_cnt SHALL increment by 1 each cycle and SHALL never wrap.
REQ-017 GRANT SHALL end on the first of three conditions, evaluated each cycle:
- done=1
- req[sel]=0
- hold_cnt==HOLD_MAX-1
REQ-018 On GRANT exit, the block SHALL:
- return to IDLE
- drive sel_valid=0 and grant=0 on the next edge
- set ptr=(sel==5)?0:sel+1
- hold sel at its last value
REQ-019 timeout SHALL pulse for exactly the one cycle after an exit caused only by hold_cnt==HOLD_MAX-1; an exit with done or req drop in the same cycle SHALL NOT pulse timeout.
REQ-020 When exit conditions coincide, the block SHALL treat it as a single exit; done and req drop take precedence over timeout.
REQ-021 Every grant SHALL be followed by at least one IDLE cycle, so grants are never back-to-back.
REQ-022 Changes to req bits other than req[sel] during GRANT SHALL have no effect until IDLE.
REQ-023 done asserted in IDLE SHALL be ignored.
REQ-024 sel SHALL change only on GRANT entry, so the downstream mux select is glitch-free between grants.
REQ-025 Grant length SHALL lie in 1..HOLD_MAX cycles inclusive.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL set state=IDLE, ptr=0, sel=3'b000, sel_valid=0, grant=6'b0, timeout=0, hold_cnt=0.
REQ-027 Reset SHALL override all activity, including mid-GRANT; no timeout pulse and no ptr advance SHALL occur on reset.
REQ-028 In the first cycle after rst_n rises, the block SHALL arbitrate normally starting from ptr=0.

Verification
REQ-029 Reset then req=6'b100100 held -> first grant sel=2, grant=6'b000100; after done, one idle cycle, then sel=5; after done, sel=2 again (rotation with wrap).
REQ-030 req=6'b000001 held, done never asserted, HOLD_MAX=8 -> sel_valid high exactly 8 cycles; timeout pulses once; one idle cycle; then sel=0 is re-granted.
REQ-031 Grant on channel 3, then req[3] dropped at cycle 2 -> sel_valid falls on the next edge; no timeout; ptr=4.
REQ-032 done and hold_cnt==HOLD_MAX-1 in the same cycle -> single exit with no timeout pulse.
REQ-033 rst_n=0 mid-GRANT on sel=4 -> next cycle shows all outputs at reset values; with req=6'b111111, the next grant is sel=0.
REQ-034 Random req/done over 10k cycles -> checker confirms:
- grant is one-hot or zero
- grant == (1<<sel) whenever sel_valid=1
- sel < 6
- grant length <= HOLD_MAX
- no channel requesting continuously is starved beyond 5 grants
